// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed FIR.
package fir_pkg;

   typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} fir_state_t;

   localparam int SAT_W = 64;

   function automatic int acc_w(input int data_w, input int coeff_w,
                                input int taps);
      return data_w + coeff_w + $clog2(taps);
   endfunction

   // Round half up, arithmetic shift, clamp to a data_w-bit signed range.
   function automatic logic signed [SAT_W-1:0] sat_round(
      input logic signed [SAT_W-1:0] acc,
      input int                      shift,
      input int                      data_w
   );
      logic signed [SAT_W-1:0] r;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      r = acc;
      if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
      r = r >>> shift;
      hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_w - 1));
      if (r > hi) r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/fir_tdm_if.sv
// Input/output streaming handshake bundle for fir_tdm.
interface fir_tdm_if #(
   parameter int DATA_W = 8
);
   logic signed [DATA_W-1:0] in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_valid;
   logic                     out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/fir_mac.sv
// Shared signed multiply-accumulate unit; clr has priority over en.
module fir_mac #(
   parameter int DATA_W  = 8,
   parameter int COEFF_W = 8,
   parameter int ACC_W   = 20
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      clr,
   input  logic                      en,
   input  logic signed [DATA_W-1:0]  a,
   input  logic signed [COEFF_W-1:0] b,
   output logic signed [ACC_W-1:0]   acc
);
   localparam int PROD_W = DATA_W + COEFF_W;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [ACC_W-1:0]  acc_q;

   always_comb begin
      prod  = PROD_W'(a) * PROD_W'(b);
      acc_d = acc_q;
      if (clr)     acc_d = '0;
      else if (en) acc_d = acc_q + ACC_W'(prod);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) acc_q <= '0;
      else          acc_q <= acc_d;
   end

   assign acc = acc_q;
endmodule

// File: rtl/fir_tdm.sv
// Time-multiplexed FIR: delay line and sequencing FSM around one MAC.
module fir_tdm
   import fir_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int COEFF_W   = 8,
   parameter int TAPS      = 11,
   parameter logic [TAPS*COEFF_W-1:0] COEFFS = {
      8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
      8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B},
   parameter int OUT_SHIFT = 0
) (
   input logic   clk,
   input logic   reset_n,
   input logic   clear,
   fir_tdm_if.slave bus
);
   localparam int ACC_W = acc_w(DATA_W, COEFF_W, TAPS);
   localparam int K_W   = $clog2(TAPS);

   fir_state_t               state_q, state_d;
   logic [K_W-1:0]           k_q, k_d;
   logic signed [DATA_W-1:0] dl_q [TAPS];
   logic signed [DATA_W-1:0] dl_d [TAPS];
   logic signed [DATA_W-1:0] out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;

   logic signed [COEFF_W-1:0] coef [TAPS];
   logic signed [ACC_W-1:0]   acc;
   logic                      accept;

   // c[0] sits in the most-significant slice of COEFFS.
   for (genvar g = 0; g < TAPS; g++) begin : g_coef
      assign coef[g] = COEFFS[(TAPS-1-g)*COEFF_W +: COEFF_W];
   end

   assign accept = bus.in_valid && (state_q == IDLE) && !clear;

   fir_mac #(
      .DATA_W  (DATA_W),
      .COEFF_W (COEFF_W),
      .ACC_W   (ACC_W)
   ) u_mac (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear | accept),
      .en      (state_q == MAC),
      .a       (dl_q[k_q]),
      .b       (coef[k_q]),
      .acc     (acc)
   );

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      dl_d        = dl_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (clear) begin
         state_d     = IDLE;
         k_d         = '0;
         dl_d        = '{default: '0};
         out_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  dl_d[0] = bus.in_data;
                  for (int i = 1; i < TAPS; i++) dl_d[i] = dl_q[i-1];
                  k_d     = '0;
                  state_d = MAC;
               end
            end
            MAC: begin
               k_d = k_q + 1'b1;
               if (k_q == K_W'(TAPS - 1)) begin
                  k_d     = '0;
                  state_d = ROUND;
               end
            end
            ROUND: begin
               out_data_d  = DATA_W'(sat_round(SAT_W'(acc),
                                               OUT_SHIFT, DATA_W));
               out_valid_d = 1'b1;
               state_d     = OUT;
            end
            OUT: begin
               if (bus.out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         dl_q        <= '{default: '0};
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         dl_q        <= dl_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_fir_tdm.sv
// Randomised self-checking bench for fir_tdm against a direct-form model.
module tb_fir_tdm;
   localparam int TAPS = 11;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clr_a = 1'b0;
   logic clr_b = 1'b0;

   int n_chk = 0;
   int n_pass = 0;
   int hist_a[$];
   int hist_b[$];

   fir_tdm_if #(.DATA_W(8)) a_if ();
   fir_tdm_if #(.DATA_W(8)) b_if ();

   fir_tdm u_a (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clr_a),
      .bus     (a_if)
   );

   fir_tdm #(.OUT_SHIFT(2)) u_b (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clr_b),
      .bus     (b_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // y = sat(round(sum c[k]*x[n-k]) >>> shift), c[k] = k+1
   function automatic int ref_y(input int h[$], input int shift);
      int s;
      s = 0;
      for (int k = 0; k < h.size(); k++) s += (k + 1) * h[k];
      if (shift > 0) s += 1 << (shift - 1);
      s = s >>> shift;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return s;
   endfunction

   task automatic xfer(input bit sb, input int x, input int hold);
      int cyc;
      int exp;
      int got;
      int timeout;
      timeout = 0;
      if (sb) begin b_if.in_data = x[7:0]; b_if.in_valid = 1'b1; end
      else    begin a_if.in_data = x[7:0]; a_if.in_valid = 1'b1; end
      while (!(sb ? b_if.in_ready : a_if.in_ready) && timeout < 100) begin
         @(posedge clk); #1;
         timeout++;
      end
      if (timeout >= 100) begin
         check("in_ready_timeout", 0, 1);
         a_if.in_valid = 1'b0;
         b_if.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if (sb) begin
         b_if.in_valid = 1'b0; b_if.in_data = 8'($urandom);
         b_if.out_ready = (hold == 0);
         hist_b.push_front(x);
         if (hist_b.size() > TAPS) void'(hist_b.pop_back());
         exp = ref_y(hist_b, 2);
      end else begin
         a_if.in_valid = 1'b0; a_if.in_data = 8'($urandom);
         a_if.out_ready = (hold == 0);
         hist_a.push_front(x);
         if (hist_a.size() > TAPS) void'(hist_a.pop_back());
         exp = ref_y(hist_a, 0);
      end
      cyc = 0;
      while (!(sb ? b_if.out_valid : a_if.out_valid) && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", cyc, 12);
      got = sb ? int'(b_if.out_data) : int'(a_if.out_data);
      check("y", got, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", int'(a_if.out_valid), 1);
         check("hold_data", int'(a_if.out_data), exp);
         check("hold_in_ready", int'(a_if.in_ready), 0);
      end
      a_if.out_ready = 1'b1;
      b_if.out_ready = 1'b1;
      @(posedge clk); #1;
      check("post_valid", int'(sb ? b_if.out_valid : a_if.out_valid), 0);
      check("post_in_ready", int'(sb ? b_if.in_ready : a_if.in_ready), 1);
   endtask

   task automatic pulse_clear_a();
      clr_a = 1'b1;
      @(posedge clk); #1;
      clr_a = 1'b0;
      hist_a.delete();
   endtask

   task automatic accept_a_then_wait(input int x, input int wait_cyc);
      a_if.in_data = x[7:0];
      a_if.in_valid = 1'b1;
      @(posedge clk); #1;
      a_if.in_valid = 1'b0;
      repeat (wait_cyc) @(posedge clk);
   endtask

   initial begin
      int nv;
      a_if.in_data = '0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
      b_if.in_data = '0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", int'(a_if.in_ready), 1);
      check("rst_out_valid", int'(a_if.out_valid), 0);
      check("rst_out_data", int'(a_if.out_data), 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // impulse, then step, then both saturation rails
      xfer(1'b0, 1, 0);
      repeat (12) xfer(1'b0, 0, 0);
      pulse_clear_a();
      repeat (13) xfer(1'b0, 1, 0);
      pulse_clear_a();
      repeat (13) xfer(1'b0, 127, 0);
      pulse_clear_a();
      repeat (13) xfer(1'b0, -128, 0);
      pulse_clear_a();
      repeat (30) xfer(1'b0, int'($urandom_range(0, 255)) - 128, 0);

      // rounding with a shift of two
      xfer(1'b1, 6, 0);
      clr_b = 1'b1;
      @(posedge clk); #1;
      clr_b = 1'b0;
      hist_b.delete();
      xfer(1'b1, -6, 0);
      repeat (10) xfer(1'b1, int'($urandom_range(0, 255)) - 128, 0);

      // backpressure held for 20 cycles
      xfer(1'b0, int'($urandom_range(0, 255)) - 128, 20);

      // clear in the middle of MAC discards the sample and the history
      pulse_clear_a();
      repeat (5) xfer(1'b0, 1, 0);
      accept_a_then_wait(1, 4);
      #1;
      clr_a = 1'b1;
      @(posedge clk); #1;
      clr_a = 1'b0;
      hist_a.delete();
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (a_if.out_valid) nv++;
      end
      check("clr_no_valid", nv, 0);
      check("clr_in_ready", int'(a_if.in_ready), 1);
      xfer(1'b0, 1, 0);

      // asynchronous reset in the middle of MAC
      repeat (5) xfer(1'b0, 1, 0);
      accept_a_then_wait(1, 4);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_out_valid", int'(a_if.out_valid), 0);
      check("arst_out_data", int'(a_if.out_data), 0);
      check("arst_in_ready", int'(a_if.in_ready), 1);
      hist_a.delete();
      hist_b.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      nv = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (a_if.out_valid) nv++;
      end
      check("arst_no_valid", nv, 0);
      xfer(1'b0, 1, 0);
      xfer(1'b0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
